// File: rtl/ro_response_collector_pkg.sv
// Shared definitions for the ring-oscillator response collector: FSM state
// encoding and the default parameter values.
package ro_response_collector_pkg;

  localparam int DEF_CHAL_BITS  = 8;
  localparam int DEF_CNT_BITS   = 16;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_WINDOW_CYC = 1024;
  localparam int DEF_RESP_BITS  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COUNT   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_STEP    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/ro_response_collector_edge_counter.sv
// Synchronizes one asynchronous ring-oscillator output, detects its rising
// edges and counts them in a saturating counter.
module ro_edge_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ro,
  input  logic                clr,
  input  logic                cnt_en,
  output logic [CNT_BITS-1:0] cnt,
  output logic                sat
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic sync1, sync2, sync2_d;
  logic rise;

  // sync1/sync2 form the metastability guard; sync2_d is only the edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= ro;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;
  assign sat  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && rise && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ro_response_collector.sv
// Runs RESP_BITS ring-oscillator races, one challenge per bit, and packs the
// "A faster than B" outcomes into a response word.
module ro_response_collector
  import ro_response_collector_pkg::*;
#(
  parameter int CHAL_BITS  = DEF_CHAL_BITS,
  parameter int CNT_BITS   = DEF_CNT_BITS,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WINDOW_CYC = DEF_WINDOW_CYC,
  parameter int RESP_BITS  = DEF_RESP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAL_BITS-1:0] chal_in,
  output logic                 chal_step,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [CHAL_BITS-1:0] mux_sel,
  output logic                 ro_en,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  output logic                 busy,
  output logic                 sat_err,
  output logic [2:0]           state_dbg,
  output logic [CNT_BITS-1:0]  cnt_a_dbg,
  output logic [CNT_BITS-1:0]  cnt_b_dbg
);

  localparam int TMR_MAX  = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int TMR_BITS = $clog2(TMR_MAX) + 1;
  localparam int IDX_BITS = $clog2(RESP_BITS + 1);
  localparam logic [TMR_BITS-1:0] SETTLE_LAST = TMR_BITS'(SETTLE_CYC - 1);
  localparam logic [TMR_BITS-1:0] WINDOW_LAST = TMR_BITS'(WINDOW_CYC - 1);
  localparam logic [IDX_BITS-1:0] IDX_END     = IDX_BITS'(RESP_BITS);

  state_t                state, state_nxt;
  logic [TMR_BITS-1:0]   timer;
  logic [IDX_BITS-1:0]   bit_idx;
  logic [RESP_BITS-1:0]  resp_shift;
  logic [CNT_BITS-1:0]   cnt_a, cnt_b;
  logic                  sat_a, sat_b;
  logic                  cnt_clr, cnt_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    chal_step = 1'b0;
    ro_en     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ro_en     = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        ro_en   = 1'b1;
        cnt_clr = 1'b1;
        if (timer == SETTLE_LAST) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        ro_en  = 1'b1;
        cnt_en = 1'b1;
        if (timer == WINDOW_LAST) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        ro_en     = 1'b1;
        state_nxt = ST_STEP;
      end
      ST_STEP: begin
        chal_step = 1'b1;
        state_nxt = (bit_idx == IDX_END) ? ST_DONE : ST_LOAD;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One timer serves both SETTLE and COUNT; it restarts on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else if (state == ST_SETTLE || state == ST_COUNT) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_sel    <= '0;
      resp_shift <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      bit_idx    <= '0;
      sat_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sat_err    <= 1'b0;
            bit_idx    <= '0;
            resp_shift <= '0;
          end
        end
        ST_LOAD: mux_sel <= chal_in;
        ST_COMPARE: begin
          resp_shift <= {resp_shift[RESP_BITS-2:0], (cnt_a > cnt_b)};
          bit_idx    <= bit_idx + 1'b1;
        end
        ST_DONE: begin
          resp_data  <= resp_shift;
          resp_valid <= 1'b1;
        end
        default: ;
      endcase
      // Counters still hold the previous run's values in LOAD, so only trust them once counting
      if ((state == ST_COUNT || state == ST_COMPARE) && (sat_a || sat_b)) sat_err <= 1'b1;
    end
  end

  ro_edge_counter #(.CNT_BITS(CNT_BITS)) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro     (ro_a),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .cnt    (cnt_a),
    .sat    (sat_a)
  );

  ro_edge_counter #(.CNT_BITS(CNT_BITS)) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro     (ro_b),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .cnt    (cnt_b),
    .sat    (sat_b)
  );

  assign state_dbg = state;
  assign cnt_a_dbg = cnt_a;
  assign cnt_b_dbg = cnt_b;

endmodule

// File: doc/ro_response_collector.md
RO_RESPONSE_COLLECTOR -- requirements
Module: ro_response_collector

Interface
REQ-001 SHALL have parameter CHAL_BITS, default 8: width of the challenge word and the mux select.
REQ-002 SHALL have parameter CNT_BITS, default 16: width of each edge counter.
REQ-003 SHALL have parameter SETTLE_CYC, default 4: cycles the oscillators run before counting starts.
REQ-004 SHALL have parameter WINDOW_CYC, default 1024: length of the counting window in cycles.
REQ-005 SHALL have parameter RESP_BITS, default 32: number of response bits per run.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset. One clock; reset is synchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit: pulse that begins a response run.
REQ-009 SHALL have port chal_in, input, CHAL_BITS: current challenge from the LFSR.
REQ-010 SHALL have port chal_step, output, 1 bit: one-cycle LFSR enable pulse that advances to the next challenge.
REQ-011 SHALL have ports ro_a and ro_b, input, 1 bit each: asynchronous outputs of the selected ring oscillators.
REQ-012 SHALL have port mux_sel, output, CHAL_BITS: latched challenge that drives the RO multiplexers.
REQ-013 SHALL have port ro_en, output, 1 bit: oscillator enable.
REQ-014 SHALL have port resp_data, output, RESP_BITS: collected response word.
REQ-015 SHALL have port resp_valid, output, 1 bit: one-cycle pulse when resp_data is complete.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port sat_err, output, 1 bit: sticky flag set when any counter saturates during a run.

Function
REQ-018 SHALL implement states IDLE, LOAD, SETTLE, COUNT, COMPARE, STEP and DONE.
REQ-019 IDLE SHALL go to LOAD when start=1; LOAD SHALL latch mux_sel<=chal_in, set ro_en=1 and clear both counters.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles with counters held at zero, then go to COUNT.
REQ-021 COUNT SHALL last exactly WINDOW_CYC cycles; each counter SHALL increment once per synchronized rising edge of its RO input.
REQ-022 Counters SHALL saturate at 2^CNT_BITS-1 and never wrap; reaching saturation SHALL set sat_err.
REQ-023 COMPARE (1 cycle) SHALL compute bit=(cnt_a>cnt_b); a tie SHALL give 0. The bit SHALL shift into resp_shift[0] while older bits move toward the MSB, and bit_idx SHALL increment.
REQ-024 STEP (1 cycle) SHALL assert chal_step=1 and ro_en=0; it SHALL go to DONE if bit_idx==RESP_BITS, else to LOAD.
REQ-025 DONE (1 cycle) SHALL copy resp_shift to resp_data, pulse resp_valid, then return to IDLE.
REQ-026 Per-bit period SHALL be P=SETTLE_CYC+WINDOW_CYC+3 cycles; resp_valid SHALL be high exactly RESP_BITS*P+1 cycles after the cycle in which start is sampled.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 resp_data SHALL hold its value until the next DONE.
REQ-029 sat_err SHALL clear when a new start is accepted.
REQ-030 Each RO input SHALL pass through a 2-FF synchronizer plus a rising-edge detector before its counter.
REQ-031 chal_step SHALL be high only in STEP, so exactly RESP_BITS pulses occur per run.

Reset
REQ-032 When rst_n=0 at a clk edge, state SHALL become IDLE and mux_sel, ro_en, chal_step, resp_data, resp_valid, busy, sat_err, bit_idx, the counters and the synchronizers SHALL all be 0.
REQ-033 Reset mid-run SHALL abort the run immediately with no resp_valid pulse and no further chal_step pulses.

Structure
REQ-034 A shared package SHALL hold the state enum and the default parameter constants.
REQ-035 The synchronizer, edge detector and saturating counter SHALL form one sub-module, ro_edge_counter, instantiated twice.

Verification (RESP_BITS=4, SETTLE_CYC=2, WINDOW_CYC=16, P=21)
REQ-036 Bench SHALL drive ro_a with a rising edge every 4 clk and ro_b every 8 clk, then pulse start; it SHALL require counts 4 and 2, resp_data=4'b1111, and resp_valid exactly at start+85.
REQ-037 Bench SHALL drive identical ro_a and ro_b; it SHALL require resp_data=0 (tie rule).
REQ-038 Bench SHALL connect the LFSR with seed 8'h01 and check that mux_sel takes the successive LFSR values and that exactly 4 chal_step pulses are seen.
REQ-039 Bench SHALL apply rst_n=0 during COUNT of bit 2; it SHALL require all outputs 0 the next cycle, no resp_valid, and a clean run after the next start.
REQ-040 Bench SHALL pulse start during busy; it SHALL require no effect on timing or results.
REQ-041 Bench SHALL set CNT_BITS=3 with ro_a edges every 2 clk; it SHALL require cnt_a held at 7 and sat_err=1 until the next start.
